// File: rtl/pipe_mem_access_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, alignment mask
// and the MEM/WB payload layout.
package pipe_mem_access_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
  } memwb_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pipe_mem_wb_reg.sv
// MEM/WB pipeline register; clr or bubble loads an all-zero entry.
module pipe_mem_wb_reg (
  input  logic        clk,
  input  logic        clr,
  input  logic        bubble,
  input  logic        d_wreg,
  input  logic        d_m2reg,
  input  logic [31:0] d_mo,
  input  logic [31:0] d_alu,
  input  logic [4:0]  d_rn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn
);

  always_ff @(posedge clk) begin
    if (clr || bubble) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmo    <= 32'd0;
      walu   <= 32'd0;
      wrn    <= 5'd0;
    end else begin
      wwreg  <= d_wreg;
      wm2reg <= d_m2reg;
      wmo    <= d_mo;
      walu   <= d_alu;
      wrn    <= d_rn;
    end
  end

endmodule

// File: rtl/pipe_mem_access.sv
// MEM stage: issues data-memory requests with a grant/rvalid handshake and
// stalls upstream until the access completes.
module pipe_mem_access
  import pipe_mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        maddr_err
);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       bubble;
  logic       mem_op;
  memwb_t     wb_next;

  assign mem_op     = mwmem | mm2reg;
  assign dmem_we    = mwmem;
  assign dmem_addr  = malu;
  assign dmem_wdata = mb;

  always_comb begin
    state_next    = state_reg;
    dmem_req      = 1'b0;
    mem_stall     = 1'b0;
    maddr_err     = 1'b0;
    bubble        = 1'b0;
    wb_next.wreg  = mwreg;
    wb_next.m2reg = 1'b0;
    wb_next.mo    = 32'd0;
    wb_next.alu   = malu;
    wb_next.rn    = mrn;
    if (clr) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_REQ: begin
          if (!mem_op) begin
            state_next = ST_IDLE;
          end else if (state_reg == ST_IDLE && is_misaligned(malu)) begin
            maddr_err = 1'b1;
            bubble    = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (!dmem_gnt) begin
              mem_stall  = 1'b1;
              bubble     = 1'b1;
              state_next = ST_REQ;
            end else if (mwmem) begin
              // store wins over load when both are set; never writes a register
              wb_next.wreg = 1'b0;
              state_next   = ST_IDLE;
            end else if (dmem_rvalid) begin
              wb_next.m2reg = 1'b1;
              wb_next.mo    = dmem_rdata;
              state_next    = ST_IDLE;
            end else begin
              mem_stall  = 1'b1;
              bubble     = 1'b1;
              state_next = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            wb_next.m2reg = 1'b1;
            wb_next.mo    = dmem_rdata;
            state_next    = ST_IDLE;
          end else begin
            mem_stall = 1'b1;
            bubble    = 1'b1;
          end
        end
        default: begin
          bubble     = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  pipe_mem_wb_reg u_mem_wb (
    .clk     (clk),
    .clr     (clr),
    .bubble  (bubble),
    .d_wreg  (wb_next.wreg),
    .d_m2reg (wb_next.m2reg),
    .d_mo    (wb_next.mo),
    .d_alu   (wb_next.alu),
    .d_rn    (wb_next.rn),
    .wwreg   (wwreg),
    .wm2reg  (wm2reg),
    .wmo     (wmo),
    .walu    (walu),
    .wrn     (wrn)
  );

endmodule
